mem_port_arbiter: RTL

- Shares one port of the 4-port `mem` unit (13-bit word address, 64-bit data, 2-bit op) between NUM_REQ requesters, e.g. host bus, ICP lanes and DMA.
- Arbitration is round-robin or fixed-priority.
- The arbiter registers the winning op onto the memory port and acks the winner.
- It tracks read latency and routes each read response back to the requester that issued it.
- It sits between the requesters and `mem`, replacing the static enable-based muxing in the top level.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_rr_arbiter.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Memory port encodings and defaults shared by the memory unit, the top
// level and the port arbiter.
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 13;
    localparam int MEM_DATA_W = 64;

    // Arbitration policies for rr_arbiter / mem_port_arbiter.
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        MEM_OP_NOP   = 2'h0,
        MEM_OP_READ  = 2'h1,
        MEM_OP_WRITE = 2'h2,
        MEM_OP_RSVD  = 2'h3
    } mem_op_e;

    // Only reads and writes compete for the port; the reserved code is a NOP.
    function automatic logic op_is_access(input logic [1:0] op);
        return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational one-of-N picker: round-robin from a pointer or fixed priority.
// Ports: i_req (request vector), i_ptr (RR start index),
//        o_gnt (one-hot grant), o_idx (grant index), o_vld (any grant).
module rr_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    // k-th candidate in search order: from the pointer with wrap in RR mode,
    // plain ascending index in fixed mode.
    function automatic logic [IDX_W-1:0] slot(
        input int               k,
        input logic [IDX_W-1:0] ptr
    );
        int s;
        s = (ARB_MODE == ARB_FIXED) ? k : k + int'(ptr);
        if (s >= N) begin
            s = s - N;
        end
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = slot(k, i_ptr);
            if (!found && i_req[cand]) begin
                o_gnt[cand] = 1'b1;
                o_idx       = cand;
                found       = 1'b1;
            end
        end
        o_vld = found;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_REQ requesters and routes read data back.
// Ports: i_req_op/addr/data (per requester, packed), o_req_ack (one-hot
//        accept), o_rsp_valid/o_rsp_data (read return), o_mem_op/addr/data
//        and i_mem_data (memory port), o_busy (read in flight).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int READ_LATENCY = 2,
    parameter int ARB_MODE     = ARB_RR
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [2*NUM_REQ-1:0]      i_req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ack,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic [1:0]                o_mem_op,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_data,
    input  logic [DATA_W-1:0]         i_mem_data,
    output logic                      o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RL    = READ_LATENCY;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic [1:0]         gnt_op;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [1:0]         mem_op_q, mem_op_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_data_q, mem_data_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    // Read tag pipeline. Stage 0 is the issue cycle itself (op on the port),
    // stage RL lines up with valid i_mem_data, which is registered into the
    // response one cycle later.
    logic [RL:0]            pipe_vld_q, pipe_vld_d;
    logic [RL:0][IDX_W-1:0] pipe_id_q, pipe_id_d;

    // A requester being acked this cycle is still holding its op; mask it.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = op_is_access(i_req_op[2*i +: 2]) && !ack_q[i];
        end
    end

    rr_arbiter #(
        .N        (NUM_REQ),
        .ARB_MODE (ARB_MODE),
        .IDX_W    (IDX_W)
    ) u_arb (
        .i_req (elig),
        .i_ptr (ptr_q),
        .o_gnt (gnt),
        .o_idx (gnt_idx),
        .o_vld (gnt_vld)
    );

    assign gnt_op = i_req_op[2*gnt_idx +: 2];

    always_comb begin
        ptr_d      = ptr_q;
        ack_d      = '0;
        mem_op_d   = MEM_OP_NOP;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (gnt_vld) begin
            ptr_d      = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : gnt_idx + 1'b1;
            ack_d      = gnt;
            mem_op_d   = gnt_op;
            mem_addr_d = i_req_addr[gnt_idx*ADDR_W +: ADDR_W];
            mem_data_d = i_req_data[gnt_idx*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        pipe_vld_d    = {pipe_vld_q[RL-1:0], gnt_vld && (gnt_op == MEM_OP_READ)};
        pipe_id_d     = pipe_id_q;
        pipe_id_d[0]  = gnt_idx;
        for (int k = 1; k <= RL; k++) begin
            pipe_id_d[k] = pipe_id_q[k-1];
        end
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (pipe_vld_q[RL]) begin
            rsp_valid_d[pipe_id_q[RL]] = 1'b1;
            rsp_data_d                 = i_mem_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q       <= '0;
            ack_q       <= '0;
            mem_op_q    <= MEM_OP_NOP;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
        end
    end

    assign o_req_ack   = ack_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_mem_op    = mem_op_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;
    assign o_busy      = |pipe_vld_q;

endmodule
